// File: rtl/ps2_scan_sequencer_if.sv
`timescale 1ns/1ps
// Key-event bus between the PS/2 scan sequencer (master) and the game
// controller (slave).
interface ps2_scan_sequencer_if;
    // evt_valid holds while the FIFO head is present and the payload is
    // stable. The event transfers on a clock edge where evt_valid and
    // evt_ready are both high. evt_ready may be driven independently of
    // evt_valid.
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       evt_game;
    logic [1:0] evt_key;

    modport master (
        output evt_valid, evt_code, evt_ext, evt_release, evt_game, evt_key,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_ext, evt_release, evt_game, evt_key,
        output evt_ready
    );
endinterface

// File: rtl/ps2_scan_sequencer.sv
`timescale 1ns/1ps
// Receives PS/2 keyboard frames and decodes E0/F0 prefixes into key events.
// Events are queued in a small FIFO for the game controller.
module ps2_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 ps2clock,
    input  logic                 ps2data,
    ps2_scan_sequencer_if.master evt,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [1:0]           state_dbg
);
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            stop_bit;
    logic [TO_W-1:0] to_cnt;

    logic start_err, to_err, check_err, frame_ok, byte_ok;
    logic ext_pend, brk_pend;
    logic is_resp, is_prefix, push;
    logic game;
    logic [1:0] key;

    logic [12:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, wr_en;
    logic [12:0]      head;

    // Synchronisers idle high so reset never looks like a clock fall.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2clock;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_err = 1'b0;
        to_err    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (fall) begin
                    if (!dat_s2) state_nxt = S_RECV;
                    else         start_err = 1'b1;
                end
            end
            S_RECV: begin
                if (fall) begin
                    if (bit_cnt == 4'd10) state_nxt = S_CHECK;
                end else if (to_cnt == TO_LAST) begin
                    to_err    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign frame_ok  = (^{shreg, par_bit}) & stop_bit;
    assign check_err = (state == S_CHECK) & ~frame_ok;
    assign byte_ok   = (state == S_CHECK) & frame_ok;
    assign frame_err = start_err | to_err | check_err;
    assign state_dbg = state;

    // Bit counter: 0 = start, 1..8 data (LSB first), 9 parity, 10 stop.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
            to_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (fall && !dat_s2) bit_cnt <= 4'd1;
                end
                S_RECV: begin
                    if (fall) begin
                        to_cnt  <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt <= 4'd8) shreg    <= {dat_s2, shreg[7:1]};
                        if (bit_cnt == 4'd9) par_bit  <= dat_s2;
                        if (bit_cnt == 4'd10) stop_bit <= dat_s2;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        is_resp = 1'b0;
        case (shreg)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
            default: is_resp = 1'b0;
        endcase
    end

    assign is_prefix = (shreg == 8'hE0) | (shreg == 8'hF0);
    assign push      = byte_ok & ~is_prefix & ~is_resp;

    // Extended codes share scan values with game keys, so they never map.
    always_comb begin
        game = 1'b0;
        key  = 2'd0;
        if (!ext_pend) begin
            case (shreg)
                8'h1C: begin game = 1'b1; key = 2'd0; end
                8'h1B: begin game = 1'b1; key = 2'd1; end
                8'h23: begin game = 1'b1; key = 2'd2; end
                8'h2B: begin game = 1'b1; key = 2'd3; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (check_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_ok) begin
            if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    assign full     = (count == FULL_CNT);
    assign pop      = evt.evt_valid & evt.evt_ready;
    assign wr_en    = push & (~full | pop);
    assign overflow = push & full & ~pop;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {shreg, ext_pend, brk_pend, game, key};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head            = mem[rd_ptr];
    assign evt.evt_valid   = (count != '0);
    assign evt.evt_code    = evt.evt_valid ? head[12:5] : 8'h00;
    assign evt.evt_ext     = evt.evt_valid & head[4];
    assign evt.evt_release = evt.evt_valid & head[3];
    assign evt.evt_game    = evt.evt_valid & head[2];
    assign evt.evt_key     = evt.evt_valid ? head[1:0] : 2'd0;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
`timescale 1ns/1ps
// Directed bench for ps2_scan_sequencer: framing, prefixes, timeout, FIFO
// overflow and reset behaviour against hand-computed events.
module tb_ps2_scan_sequencer;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;
    localparam int GAP   = 60;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    logic ps2clock = 1'b1;
    logic ps2data  = 1'b1;
    logic frame_err, overflow;
    logic [1:0] state_dbg;

    ps2_scan_sequencer_if evt_if ();

    ps2_scan_sequencer #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .ps2clock (ps2clock),
        .ps2data  (ps2data),
        .evt      (evt_if.master),
        .frame_err(frame_err),
        .overflow (overflow),
        .state_dbg(state_dbg)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [12:0] head;
    logic [12:0] exp_q[$];
    assign head = {evt_if.evt_code, evt_if.evt_ext, evt_if.evt_release,
                   evt_if.evt_game, evt_if.evt_key};

    always @(posedge CLOCK_50) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [12:0] ev(input logic [7:0] c, input logic x,
                                       input logic r, input logic g, input logic [1:0] k);
        return {c, x, r, g, k};
    endfunction

    // bits[0] is the start bit; odd parity is ~^code.
    function automatic logic [10:0] frame(input logic [7:0] c, input logic flip,
                                          input logic stp, input logic st);
        return {stp, (~^c) ^ flip, c, st};
    endfunction

    // Returns at the negedge where the last clock fall was driven.
    task automatic drive_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2data = bits[i];
            repeat (HALF) @(negedge CLOCK_50);
            ps2clock = 1'b0;
            if (i != n - 1) begin
                repeat (HALF) @(negedge CLOCK_50);
                ps2clock = 1'b1;
            end
        end
    endtask

    task automatic end_frame;
        repeat (HALF) @(negedge CLOCK_50);
        ps2clock = 1'b1;
        ps2data  = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);
    endtask

    // fe/ov/v1 sampled in the CHECK cycle, v2 one cycle later.
    task automatic send_frame(input logic [10:0] bits, output logic fe, output logic ov,
                              output logic v1, output logic v2);
        drive_bits(bits, 11);
        repeat (3) @(negedge CLOCK_50);
        fe = frame_err;
        ov = overflow;
        v1 = evt_if.evt_valid;
        @(negedge CLOCK_50);
        v2 = evt_if.evt_valid;
        end_frame();
    endtask

    task automatic pop_one(output logic [12:0] h);
        h = head;
        evt_if.evt_ready = 1'b1;
        @(negedge CLOCK_50);
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        n_chk++;
        if ({evt_if.evt_valid, head, frame_err, overflow} !== 16'h0)
            $display("FAIL reset_outputs_low: got %b want 0", {evt_if.evt_valid, head, frame_err, overflow});
        else n_pass++;
        n_chk++;
        if (state_dbg !== 2'd0) $display("FAIL reset_state_low: got %0d want 0", state_dbg);
        else n_pass++;
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_chk++;
        if ({evt_if.evt_valid, head, frame_err, overflow} !== 16'h0)
            $display("FAIL reset_outputs_after: got %b want 0", {evt_if.evt_valid, head, frame_err, overflow});
        else n_pass++;
        n_chk++;
        if (state_dbg !== 2'd0) $display("FAIL reset_state_after: got %0d want 0", state_dbg);
        else n_pass++;
    endtask

    task automatic test_make_code;
        logic fe, ov, v1, v2;
        logic [12:0] h;
        send_frame(frame(8'h1C, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        n_chk++;
        if ({fe, v1, v2} !== 3'b001) $display("FAIL make_timing: got fe/v1/v2=%b want 001", {fe, v1, v2});
        else n_pass++;
        n_chk++;
        if (head !== ev(8'h1C, 0, 0, 1, 2'd0)) $display("FAIL make_head: got %h want %h", head, ev(8'h1C, 0, 0, 1, 2'd0));
        else n_pass++;
        repeat (50) @(negedge CLOCK_50);
        n_chk++;
        if ({evt_if.evt_valid, head} !== {1'b1, ev(8'h1C, 0, 0, 1, 2'd0)})
            $display("FAIL make_hold: got %b/%h want 1/%h", evt_if.evt_valid, head, ev(8'h1C, 0, 0, 1, 2'd0));
        else n_pass++;
        pop_one(h);
        n_chk++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL make_popped: got valid %b want 0", evt_if.evt_valid);
        else n_pass++;
    endtask

    task automatic test_break;
        logic fe, ov, v1, v2;
        logic [12:0] h;
        send_frame(frame(8'hF0, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        n_chk++;
        if (v2 !== 1'b0) $display("FAIL break_prefix_no_event: got %b want 0", v2);
        else n_pass++;
        send_frame(frame(8'h2B, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        pop_one(h);
        n_chk++;
        if (h !== ev(8'h2B, 0, 1, 1, 2'd3)) $display("FAIL break_event: got %h want %h", h, ev(8'h2B, 0, 1, 1, 2'd3));
        else n_pass++;
        n_chk++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL break_single: got valid %b want 0", evt_if.evt_valid);
        else n_pass++;
        send_frame(frame(8'hE0, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        send_frame(frame(8'h2B, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        pop_one(h);
        n_chk++;
        if (h !== ev(8'h2B, 1, 0, 0, 2'd0)) $display("FAIL ext_event: got %h want %h", h, ev(8'h2B, 1, 0, 0, 2'd0));
        else n_pass++;
    endtask

    task automatic test_frame_errors;
        logic fe, ov, v1, v2;
        logic [12:0] h;
        int f0;
        f0 = fe_cnt;
        send_frame(frame(8'h1C, 1'b1, 1'b1, 1'b0), fe, ov, v1, v2);
        n_chk++;
        if ({fe, v2} !== 2'b10) $display("FAIL parity_err: got fe/v2=%b want 10", {fe, v2});
        else n_pass++;
        n_chk++;
        if (fe_cnt - f0 !== 1) $display("FAIL parity_pulse_count: got %0d want 1", fe_cnt - f0);
        else n_pass++;
        send_frame(frame(8'h1C, 1'b0, 1'b0, 1'b0), fe, ov, v1, v2);
        n_chk++;
        if ({fe, v2} !== 2'b10) $display("FAIL stop_err: got fe/v2=%b want 10", {fe, v2});
        else n_pass++;
        ps2data = 1'b1;
        repeat (HALF) @(negedge CLOCK_50);
        ps2clock = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        n_chk++;
        if (frame_err !== 1'b1) $display("FAIL start_err: got %b want 1", frame_err);
        else n_pass++;
        @(negedge CLOCK_50);
        n_chk++;
        if (state_dbg !== 2'd0) $display("FAIL start_stay_idle: got %0d want 0", state_dbg);
        else n_pass++;
        end_frame();
        send_frame(frame(8'hF0, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        send_frame(frame(8'h1C, 1'b1, 1'b1, 1'b0), fe, ov, v1, v2);
        send_frame(frame(8'h1C, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        n_chk++;
        if (v2 !== 1'b1) $display("FAIL err_clears_prefix_valid: got %b want 1", v2);
        else n_pass++;
        pop_one(h);
        n_chk++;
        if (h !== ev(8'h1C, 0, 0, 1, 2'd0)) $display("FAIL err_clears_prefix: got %h want %h", h, ev(8'h1C, 0, 0, 1, 2'd0));
        else n_pass++;
    endtask

    task automatic test_timeout;
        logic fe, ov, v1, v2;
        logic [12:0] h;
        int f0;
        f0 = fe_cnt;
        drive_bits(frame(8'h1B, 1'b0, 1'b1, 1'b0), 5);
        repeat (HALF) @(negedge CLOCK_50);
        ps2clock = 1'b1;
        n_chk++;
        if ({state_dbg, 8'(fe_cnt - f0)} !== {2'd1, 8'd0})
            $display("FAIL timeout_mid_frame: got state %0d errs %0d want 1 0", state_dbg, fe_cnt - f0);
        else n_pass++;
        repeat (TO + 20) @(negedge CLOCK_50);
        n_chk++;
        if (fe_cnt - f0 !== 1) $display("FAIL timeout_pulse: got %0d want 1", fe_cnt - f0);
        else n_pass++;
        n_chk++;
        if (state_dbg !== 2'd0) $display("FAIL timeout_idle: got %0d want 0", state_dbg);
        else n_pass++;
        ps2data = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);
        send_frame(frame(8'h1B, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        pop_one(h);
        n_chk++;
        if ({v2, h} !== {1'b1, ev(8'h1B, 0, 0, 1, 2'd1)})
            $display("FAIL timeout_recover: got %b/%h want 1/%h", v2, h, ev(8'h1B, 0, 0, 1, 2'd1));
        else n_pass++;
    endtask

    task automatic test_fifo_overflow;
        logic fe, ov, v1, v2;
        logic [7:0] codes [5];
        int o0;
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h15};
        exp_q = '{ev(8'h1C, 0, 0, 1, 2'd0), ev(8'h1B, 0, 0, 1, 2'd1),
                  ev(8'h23, 0, 0, 1, 2'd2), ev(8'h2B, 0, 0, 1, 2'd3)};
        o0 = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(frame(codes[i], 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
            n_chk++;
            if (ov !== (i == 4)) $display("FAIL overflow_push%0d: got %b want %b", i, ov, (i == 4));
            else n_pass++;
        end
        n_chk++;
        if (ov_cnt - o0 !== 1) $display("FAIL overflow_count: got %0d want 1", ov_cnt - o0);
        else n_pass++;
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (head !== exp_q[0]) $display("FAIL drain_%0d: got %h want %h", i, head, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            @(negedge CLOCK_50);
        end
        evt_if.evt_ready = 1'b0;
        n_chk++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", evt_if.evt_valid);
        else n_pass++;
    endtask

    task automatic test_full_pop_push;
        logic fe, ov, v1, v2;
        logic [7:0] codes [4];
        int o0;
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
        for (int i = 0; i < 4; i++) send_frame(frame(codes[i], 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        o0 = ov_cnt;
        drive_bits(frame(8'h15, 1'b0, 1'b1, 1'b0), 11);
        repeat (3) @(negedge CLOCK_50);
        evt_if.evt_ready = 1'b1;
        #1;
        n_chk++;
        if (overflow !== 1'b0) $display("FAIL full_pop_push_ovf: got %b want 0", overflow);
        else n_pass++;
        @(negedge CLOCK_50);
        evt_if.evt_ready = 1'b0;
        end_frame();
        n_chk++;
        if (ov_cnt - o0 !== 0) $display("FAIL full_pop_push_count: got %0d want 0", ov_cnt - o0);
        else n_pass++;
        exp_q = '{ev(8'h1B, 0, 0, 1, 2'd1), ev(8'h23, 0, 0, 1, 2'd2),
                  ev(8'h2B, 0, 0, 1, 2'd3), ev(8'h15, 0, 0, 0, 2'd0)};
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if ({evt_if.evt_valid, head} !== {1'b1, exp_q[0]})
                $display("FAIL full_drain_%0d: got %b/%h want 1/%h", i, evt_if.evt_valid, head, exp_q[0]);
            else n_pass++;
            void'(exp_q.pop_front());
            @(negedge CLOCK_50);
        end
        evt_if.evt_ready = 1'b0;
        n_chk++;
        if (evt_if.evt_valid !== 1'b0) $display("FAIL full_drain_empty: got %b want 0", evt_if.evt_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic fe, ov, v1, v2;
        logic [12:0] h;
        int f0;
        send_frame(frame(8'h1C, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        drive_bits(frame(8'h2B, 1'b0, 1'b1, 1'b0), 5);
        repeat (HALF) @(negedge CLOCK_50);
        ps2clock = 1'b1;
        n_chk++;
        if ({evt_if.evt_valid, state_dbg} !== 3'b101)
            $display("FAIL pre_reset: got valid %b state %0d want 1 1", evt_if.evt_valid, state_dbg);
        else n_pass++;
        f0 = fe_cnt;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({evt_if.evt_valid, head, frame_err, overflow, state_dbg} !== 18'h0)
            $display("FAIL mid_reset_outputs: got %b want 0", {evt_if.evt_valid, head, frame_err, overflow, state_dbg});
        else n_pass++;
        repeat (5) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (GAP) @(negedge CLOCK_50);
        n_chk++;
        if ({evt_if.evt_valid, 8'(fe_cnt - f0)} !== 9'h0)
            $display("FAIL mid_reset_quiet: got valid %b errs %0d want 0 0", evt_if.evt_valid, fe_cnt - f0);
        else n_pass++;
        send_frame(frame(8'h23, 1'b0, 1'b1, 1'b0), fe, ov, v1, v2);
        pop_one(h);
        n_chk++;
        if ({v2, h} !== {1'b1, ev(8'h23, 0, 0, 1, 2'd2)})
            $display("FAIL post_reset_event: got %b/%h want 1/%h", v2, h, ev(8'h23, 0, 0, 1, 2'd2));
        else n_pass++;
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_make_code();
        test_break();
        test_frame_errors();
        test_timeout();
        test_fifo_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_scan_sequencer.md
# ps2_scan_sequencer

Sequences reception of PS/2 keyboard frames in the CLOCK_50 domain and turns raw scan codes into discrete key events for the game logic. It synchronises the keyboard's ps2clock and ps2data lines, frames and checks each 11-bit packet, tracks E0 (extended) and F0 (break) prefixes, and maps the four game keys to a 2-bit code. Events are buffered in a small FIFO and handed to the downstream whack-a-mole controller over a valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 50000, CLOCK_50 cycles allowed between ps2clock falling edges inside a frame (1 ms at 50 MHz).
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.

- CLOCK_50  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- ps2clock  in  1  raw keyboard clock pin; asynchronous.
- ps2data  in  1  raw keyboard data pin; asynchronous.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_code  out  8  scan code of the head event.
- evt_ext  out  1  head event was E0-prefixed.
- evt_release  out  1  head event was F0-prefixed (key up).
- evt_game  out  1  head event is a game key.
- evt_key  out  2  game key index: 1C→0, 1B→1, 23→2, 2B→3. Zero when evt_game=0.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Synchroniser.** ps2clock and ps2data each pass through two flops, and a third flop holds the previous synced clock.
  - fall = prev & ~sync_clk.
  - Data is sampled from the synced data on the cycle fall is asserted.
- **Framer states.** IDLE, RECV, CHECK.
  - IDLE: on fall, if the data bit is 0 (start bit), go to RECV with bit count 1. If the data bit is 1, pulse frame_err and stay in IDLE.
  - RECV: each fall captures one bit.
    - Bits 1–8 are data, LSB first, into an 8-bit shift register.
    - Bit 9 is parity.
    - Bit 10 is stop; capturing it moves the framer to CHECK.
  - RECV timeout: a cycle counter clears on every fall. If it reaches TIMEOUT_CYCLES-1 with no new fall, pulse frame_err and go to IDLE.
  - CHECK (exactly one cycle): the frame is valid only if parity is odd over the 8 data bits plus the parity bit, and stop = 1.
    - Invalid frame: pulse frame_err and clear both prefix flags.
    - Valid frame: hand the byte to the decoder.
    - Always return to IDLE afterwards.
- **Decoder.** Holds prefix flags ext_pend and brk_pend.
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - 00, AA, EE, FA, FC, FE, FF are device responses: swallow them and clear both flags.
  - Any other byte pushes the event {code, ext_pend, brk_pend, game, key}, then clears both flags.
  - game = 1 only when ext_pend = 0 and the code is 1C, 1B, 23 or 2B.
- **Event FIFO.**
  - Push on a decoder event.
  - Pop when evt_valid & evt_ready.
  - Outputs show the head entry directly from storage, not through a combinational path from inputs.
  - Full and no pop on a push: drop the new event, pulse overflow, existing contents unchanged.
  - Full with simultaneous pop and push: both occur, no overflow.
  - Empty with simultaneous push and pop: a pop is not possible because evt_valid = 0; the push lands.
- **Reset.**
  - Clears the synchroniser flops to 1 (idle bus level).
  - Clears framer to IDLE, counters, flags, FIFO pointers and data.
  - All outputs read 0 during and after reset.
  - Reset mid-frame discards the partial frame with no frame_err.

## Timing
- Synchroniser latency: 2 cycles from pin edge to sync_clk. fall is asserted in cycle E.
- Stop-bit fall in cycle E: CHECK occurs in E+1, the FIFO write happens at the end of E+1, and evt_valid = 1 at E+2 if the FIFO was empty.
- frame_err on parity or stop failure is asserted in E+1.
- frame_err on timeout is asserted in the cycle the counter hits TIMEOUT_CYCLES-1.
- Pop takes effect at the clock edge where valid & ready. The next head appears the following cycle. Back-to-back pops are allowed, one per cycle.
- ps2clock is roughly 10–16.7 kHz, so there are 1500+ CLOCK_50 cycles between falls. The framer never sees two falls within CHECK.

## Test plan
- **Make code.** Frame 1C: start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1, with evt_ready = 0 → evt_valid = 1 at E+2, evt_code = 1C, evt_game = 1, evt_key = 0, evt_release = 0. The outputs hold until ready.
- **Break sequence.** F0 then 2B → exactly one event, with evt_release = 1, evt_key = 3.
  - E0 then 2B → evt_ext = 1, evt_game = 0, evt_key = 0.
- **Framing errors.**
  - Parity bit flipped → frame_err pulses in E+1, no event.
  - Stop bit = 0 → frame_err, no event.
  - Start bit = 1 → frame_err, the framer stays in IDLE.
  - F0, then a bad frame, then 1C → 1C is reported with evt_release = 0.
- **Timeout.** Send 5 bits, then hold ps2clock high for TIMEOUT_CYCLES → one frame_err pulse. A following clean 1B frame yields evt_key = 1.
- **FIFO.** With evt_ready = 0, send 5 valid codes at FIFO_DEPTH = 4 → one overflow pulse on the 5th, and the 4 events pop in order.
  - Full FIFO with evt_ready = 1 in the push cycle → no overflow, 4 entries remain.
- **Reset.** Assert resetn = 0 mid-frame and with a non-empty FIFO → all outputs 0 immediately. After release, a clean 23 frame → evt_key = 2.
